// File: rtl/systolic_pkg.sv
// Shared types and default sizing for the systolic array result path.
// Holds the drain FSM state encoding used by result_drain.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH
  } drain_state_t;

  localparam int DEF_ARRAY_SIZE = 8;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_OUT_WIDTH  = 16;

endpackage

// File: rtl/result_narrow.sv
// Per-lane arithmetic shift and narrowing of one accumulator value.
// RESULT_SAT_EN selects clamping; otherwise the low bits wrap.
module result_narrow
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int SHIFT      = 0
) (
  input  logic signed [DATA_WIDTH-1:0] i_val,
  output logic signed [OUT_WIDTH-1:0]  o_val
);

`ifdef RESULT_SAT_EN
  localparam logic signed [DATA_WIDTH-1:0] MAXV =
    {{(DATA_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] MINV =
    {{(DATA_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic signed [DATA_WIDTH-1:0] w_sh;

  assign w_sh = i_val >>> SHIFT;

  always_comb begin
    o_val = OUT_WIDTH'(w_sh);
    if (w_sh > MAXV)
      o_val = OUT_WIDTH'(MAXV);
    else if (w_sh < MINV)
      o_val = OUT_WIDTH'(MINV);
  end
`else
  assign o_val = OUT_WIDTH'(i_val >>> SHIFT);
`endif

endmodule

// File: rtl/result_drain.sv
// Drains one tile from the deskew buffer as a row stream, row N-1 first.
// Narrowing mode is chosen by RESULT_SAT_EN (see result_narrow).
module result_drain
  import systolic_pkg::*;
#(
  parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int SHIFT      = 0,
  localparam int IDX_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 buf_read_valid,
  input  logic signed [ARRAY_SIZE*DATA_WIDTH-1:0] buf_data,
  output logic                                 buf_read,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic signed [ARRAY_SIZE*OUT_WIDTH-1:0]  out_data,
  output logic [IDX_W-1:0]                     out_row_idx,
  output logic                                 out_last,
  output logic                                 busy,
  output logic                                 done
);

  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ARRAY_SIZE-1);

  drain_state_t                        r_state;
  logic [IDX_W-1:0]                    r_row_cnt;
  logic                                r_out_valid;
  logic                                r_out_last;
  logic                                r_done;
  logic [IDX_W-1:0]                    r_out_idx;
  logic [ARRAY_SIZE*OUT_WIDTH-1:0]     r_out_data;
  logic [ARRAY_SIZE*OUT_WIDTH-1:0]     w_conv;
  logic                                w_take;

  for (genvar g = 0; g < ARRAY_SIZE; g++) begin : g_lane
    result_narrow #(
      .DATA_WIDTH(DATA_WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .SHIFT     (SHIFT)
    ) u_narrow (
      .i_val(buf_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .o_val(w_conv[g*OUT_WIDTH +: OUT_WIDTH])
    );
  end

  assign w_take = !r_out_valid || out_ready;

  // Combinational so the buffer pointer moves on the same edge as the capture.
  assign buf_read    = (r_state == DRAIN) && w_take;
  assign busy        = (r_state != IDLE);
  assign out_valid   = r_out_valid;
  assign out_last    = r_out_last;
  assign out_row_idx = r_out_idx;
  assign out_data    = r_out_data;
  assign done        = r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_row_cnt   <= LAST_ROW;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
      r_out_idx   <= '0;
      r_out_data  <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start && buf_read_valid) begin
            r_state   <= DRAIN;
            r_row_cnt <= LAST_ROW;
          end
        end
        DRAIN: begin
          if (w_take) begin
            r_out_data  <= w_conv;
            r_out_idx   <= r_row_cnt;
            r_out_valid <= 1'b1;
            r_out_last  <= (r_row_cnt == '0);
            if (r_row_cnt == '0)
              r_state <= FLUSH;
            else
              r_row_cnt <= r_row_cnt - 1'b1;
          end
        end
        FLUSH: begin
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_drain.sv
// Scoreboard bench for result_drain (ARRAY_SIZE=8, SHIFT=4).
// Expected rows come from a reference conversion of the buffer model.
module tb_result_drain;

  localparam int N  = 8;
  localparam int DW = 32;
  localparam int OW = 16;
  localparam int SH = 4;
  localparam int VW = N*OW;

  logic              clk = 0;
  logic              rst = 0;
  logic              start = 0;
  logic              buf_read_valid = 0;
  logic              out_ready = 1;
  logic [N*DW-1:0]   buf_data;
  logic              buf_read;
  logic              out_valid;
  logic [VW-1:0]     out_data;
  logic [2:0]        out_row_idx;
  logic              out_last;
  logic              busy;
  logic              done;

  result_drain #(
    .ARRAY_SIZE(N),
    .DATA_WIDTH(DW),
    .OUT_WIDTH (OW),
    .SHIFT     (SH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .buf_read_valid(buf_read_valid),
    .buf_data      (buf_data),
    .buf_read      (buf_read),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_row_idx   (out_row_idx),
    .out_last      (out_last),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VW-1:0] d;
    int            idx;
    bit            last;
  } exp_t;

  exp_t q[$];
  exp_t e;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int hs_cnt = 0;
  int first_v = -1;
  int last_hs = 0;
  bit lane_chk = 0;
  bit stalled = 0;
  logic [VW-1:0] held_d;
  logic [2:0]    held_i;

  int rows [N][N];
  logic [2:0] ptr = 3'd7;
  logic ld = 0;

  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] conv(int v);
    int s;
    s = v >>> SH;
`ifdef RESULT_SAT_EN
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
`endif
    return s[OW-1:0];
  endfunction

  function automatic logic [VW-1:0] exp_row(int k);
    logic [VW-1:0] r;
    r = '0;
    for (int l = 0; l < N; l++) r[l*OW +: OW] = conv(rows[k][l]);
    return r;
  endfunction

  // Deskew buffer model: row pointer decrements on each buf_read.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ld) ptr <= 3'd7;
    else if (buf_read) ptr <= ptr - 3'd1;
  end

  always_comb begin
    buf_data = '0;
    for (int l = 0; l < N; l++) buf_data[l*DW +: DW] = rows[ptr][l];
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (buf_read) rd_cnt++;
      if (out_valid && first_v < 0) first_v = cyc;
      if (stalled) begin
        chk("hold_data", out_data, held_d);
        chk("hold_idx", out_row_idx, held_i);
      end
      if (out_valid && !out_ready) chk("stall_rd", buf_read, 0);
      if (out_valid && out_ready) begin
        hs_cnt++;
        last_hs = cyc;
        if (q.size() == 0) chk("extra_row", 1, 0);
        else begin
          e = q.pop_front();
          chk("row_data", out_data, e.d);
          chk("row_idx", out_row_idx, e.idx);
          chk("row_last", out_last, e.last);
        end
        if (lane_chk && out_row_idx == 3'd7) begin
          chk("lane_neg", $signed(out_data[OW-1:0]), -2500);
`ifdef RESULT_SAT_EN
          chk("lane_big", $signed(out_data[2*OW-1:OW]), 32767);
`else
          chk("lane_big", $signed(out_data[2*OW-1:OW]), -3036);
`endif
        end
      end
      stalled = out_valid && !out_ready;
      held_d  = out_data;
      held_i  = out_row_idx;
    end else begin
      stalled = 0;
    end
  end

  task automatic load_ramp();
    for (int k = 0; k < N; k++)
      for (int l = 0; l < N; l++) rows[k][l] = 100*k;
  endtask

  task automatic load_mix();
    int tbl [N];
    tbl = '{-40000, 1000000, -1000000, 524287, -524289, 0, -1, -17};
    for (int k = 0; k < N; k++)
      for (int l = 0; l < N; l++) rows[k][l] = tbl[(l + 7 - k) % N];
  endtask

  task automatic push_tile();
    for (int k = N-1; k >= 0; k--) q.push_back('{exp_row(k), k, k == 0});
  endtask

  // mode 0: ready=1; 1: ready 1,0,0,...; 2: ready=1 plus start mid-drain
  task automatic run_tile(input int mode, input bit timing);
    int t0;
    int done_t;
    bit got;
    t0 = 0; done_t = 0; got = 0;
    rd_cnt = 0; hs_cnt = 0; first_v = -1;
    push_tile();
    ld = 1;
    for (int c = 0; c < 200 && !got; c++) begin
      @(posedge clk); #1;
      ld = 0;
      start = (c == 0) || (mode == 2 && c == 3);
      buf_read_valid = 1;
      out_ready = (mode == 1) ? (c % 3 == 0) : 1'b1;
      if (c == 0) t0 = cyc + 1;
      if (c == 1) chk("busy_on", busy, 1);
      @(negedge clk);
      if (done) begin
        got = 1;
        done_t = cyc;
      end
    end
    start = 0;
    out_ready = 1;
    if (!got) chk("done_timeout", 0, 1);
    chk("rd_cnt", rd_cnt, N);
    chk("q_empty", q.size(), 0);
    if (timing) begin
      chk("first_valid_t", first_v - t0, 1);
      chk("last_row_t", last_hs - t0, N);
      chk("done_t", done_t - t0, N+1);
    end
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("busy_off", busy, 0);
  endtask

  initial begin
    load_ramp();
    #2 rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_rd", buf_read, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);
    chk("rst_idx", out_row_idx, 0);
    @(negedge clk) rst = 0;

    // ramp tile, full throughput with latency checks
    run_tile(0, 1);

    // backpressure
    run_tile(1, 0);

    // shift and narrowing corner values
    load_mix();
    lane_chk = 1;
    run_tile(0, 1);
    lane_chk = 0;

    // start with no tile available
    @(posedge clk); #1;
    rd_cnt = 0;
    start = 1;
    buf_read_valid = 0;
    @(posedge clk); #1;
    start = 0;
    repeat (3) @(negedge clk);
    chk("nostart_busy", busy, 0);
    chk("nostart_valid", out_valid, 0);
    chk("nostart_rd", rd_cnt, 0);

    // start during drain is dropped
    load_ramp();
    run_tile(2, 0);

    // reset mid-tile after 3 rows
    hs_cnt = 0;
    push_tile();
    ld = 1;
    for (int c = 0; c < 50 && hs_cnt < 3; c++) begin
      @(posedge clk); #1;
      ld = 0;
      start = (c == 0);
      buf_read_valid = 1;
      out_ready = 1;
      @(negedge clk);
    end
    chk("pre_rst_rows", hs_cnt, 3);
    #2 rst = 1;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_rd", buf_read, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_last", out_last, 0);
    chk("abort_data", out_data, 0);
    chk("abort_idx", out_row_idx, 0);
    q.delete();
    repeat (2) @(posedge clk);
    #2 rst = 0;
    run_tile(0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
